hls_activity_monitor: RTL and testbench
=======================================

# hls_activity_monitor

Synthesizable activity monitor for one HLS-generated function and its loops. It watches one block-level handshake (ap_start/ap_ready/ap_done/ap_continue), one sequential FSM loop and one pipelined loop. It turns them into registered counters: transaction count, latency, busy cycles, loop entries, iteration completions and pipeline stall cycles. It sits beside the DUT in simulation or in an on-chip debug wrapper, taps the DUT's control signals directly, and never drives the DUT.

## Interface
Parameters:
- SEQ_W, 6: width of the sequential-loop FSM state vector (one-hot encoding).
- UPC_W, 17: width of the pipelined-loop FSM state vector (one-hot encoding).
- CNT_W, 32: width of every counter output.

Ports:
- clock  in  1  Single clock; all logic updates on the rising edge.
- reset  in  1  Reset; synchronous and active-high. Clears all state.
- finish  in  1  End-of-measurement strobe. Freezes all counters (sticky).
- mod_ap_start, mod_ap_ready, mod_ap_done, mod_ap_continue  in  1 each  Monitored block handshake.
- seq_cur_state, seq_pre_state, seq_post_state, seq_quit_state, seq_iter_start_state, seq_iter_end_state  in  SEQ_W each  Current FSM state, plus the state encodings that mark loop entry, exit and iteration boundaries.
- upc_cur_state, upc_iter_start_state, upc_iter_end_state  in  UPC_W each  Pipelined-loop FSM state and its stage encodings.
- upc_iter_start_block, upc_iter_end_block  in  1 each  Stage subdone-block flags.
- upc_iter_start_enable, upc_iter_end_enable  in  1 each  Pipeline enable registers for the first and last stage.
- upc_loop_start, upc_loop_done, upc_loop_continue  in  1 each  Loop-module handshake.
- mod_active, seq_active, upc_active, frozen  out  1 each  Status flags.
- mod_txn_count, mod_busy_cycles, mod_last_latency  out  CNT_W each  Block-level statistics.
- seq_loop_count, seq_iter_count  out  CNT_W each  Sequential-loop statistics.
- upc_loop_count, upc_iter_started, upc_iter_done, upc_stall_cycles  out  CNT_W each  Pipelined-loop statistics.

## Operation
- All outputs are registered. Every counter saturates at all-ones and never wraps.
- "State X matches" means an equality compare on the full state vector.
- Module tracker, two states IDLE and BUSY, with an internal latency counter L.
  - IDLE with start=1 and done&&continue=1 in the same cycle: txn_count+1, last_latency=1, stay IDLE.
  - IDLE with start=1 otherwise: go to BUSY, L=1.
  - BUSY without done&&continue: L+1.
  - BUSY with done&&continue: txn_count+1, last_latency=L+1, go to IDLE. A start asserted in that same cycle is ignored; a start still high next cycle begins a new transaction.
  - busy_cycles increments every cycle that is BUSY or IDLE&&start.
  - mod_active = (state==BUSY).
  - mod_ap_ready is accepted as an input but does not affect any counter.
- Sequential loop tracker. The previous cycle's seq_cur_state is registered as prev.
  - Entry: prev==pre_state and cur==iter_start_state. Sets seq_active and increments seq_loop_count.
  - Completion, while active: prev==iter_end_state and cur!=iter_end_state. Increments seq_iter_count.
  - Exit: prev==quit_state and cur==post_state. Clears seq_active.
  - If entry and exit conditions hold in the same cycle, entry wins.
- Pipelined loop tracker.
  - upc_active is set when upc_loop_start=1 and the tracker is inactive; upc_loop_count+1 on that event.
  - upc_active is cleared when upc_loop_done&&upc_loop_continue.
  - upc_iter_started+1 when cur==iter_start_state && iter_start_enable && !iter_start_block.
  - upc_iter_done+1 when cur==iter_end_state && iter_end_enable && !iter_end_block.
  - upc_stall_cycles+1 when upc_active && cur==iter_start_state && iter_start_block.
  - Iteration events count regardless of upc_active.
- Freeze: when finish is sampled high, frozen=1 from the next cycle until reset. While frozen, all counters and active flags hold their values.

## Timing
- Reset: every output and internal register is 0. The prev registers reset to 0, so no entry can be detected in the first cycle after reset.
- Every event is reflected on the outputs one cycle after the qualifying input cycle.
- The finish cycle itself still updates counters; updates stop from the following cycle.
- Asserting reset while active returns everything to 0 on the next edge, including frozen.

## Test plan
- Single transaction: mod_ap_start high for 1 cycle, mod_ap_done&&continue 4 cycles later -> mod_txn_count=1, mod_last_latency=5, mod_busy_cycles=5, mod_active=0.
- Same-cycle start and done in IDLE (1-cycle function), repeated 3 times -> mod_txn_count=3, mod_last_latency=1, mod_active never 1.
- Sequential loop, state sequence 4→5→6→5→6→5→6→5→1 with pre=4, start=quit=5, end=6, post=1 -> seq_loop_count=1, seq_iter_count=3, seq_active=0 at end.
- Pipelined loop: loop_start, 10 accepted starts, 2 cycles of start_block in the start state, 10 accepted ends, loop_done -> upc_loop_count=1, upc_iter_started=10, upc_iter_done=10, upc_stall_cycles=2.
- Freeze: finish pulse mid-transaction followed by more done events -> every counter holds its post-finish-cycle value and frozen=1; then reset -> all outputs 0.
- Saturation with CNT_W=4: 20 transactions -> mod_txn_count=15.

Source files
------------

// File: rtl/hls_activity_monitor_if.sv
// Tap bundle for hls_activity_monitor: the monitored HLS control signals
// (driven by whoever owns the DUT) and the statistics the monitor reports.
interface hls_activity_monitor_if #(
  parameter int SEQ_W = 6,
  parameter int UPC_W = 17,
  parameter int CNT_W = 32
);
  logic             finish;
  logic             mod_ap_start;
  logic             mod_ap_ready;
  logic             mod_ap_done;
  logic             mod_ap_continue;
  logic [SEQ_W-1:0] seq_cur_state;
  logic [SEQ_W-1:0] seq_pre_state;
  logic [SEQ_W-1:0] seq_post_state;
  logic [SEQ_W-1:0] seq_quit_state;
  logic [SEQ_W-1:0] seq_iter_start_state;
  logic [SEQ_W-1:0] seq_iter_end_state;
  logic [UPC_W-1:0] upc_cur_state;
  logic [UPC_W-1:0] upc_iter_start_state;
  logic [UPC_W-1:0] upc_iter_end_state;
  logic             upc_iter_start_block;
  logic             upc_iter_end_block;
  logic             upc_iter_start_enable;
  logic             upc_iter_end_enable;
  logic             upc_loop_start;
  logic             upc_loop_done;
  logic             upc_loop_continue;

  logic             mod_active;
  logic             seq_active;
  logic             upc_active;
  logic             frozen;
  logic [CNT_W-1:0] mod_txn_count;
  logic [CNT_W-1:0] mod_busy_cycles;
  logic [CNT_W-1:0] mod_last_latency;
  logic [CNT_W-1:0] seq_loop_count;
  logic [CNT_W-1:0] seq_iter_count;
  logic [CNT_W-1:0] upc_loop_count;
  logic [CNT_W-1:0] upc_iter_started;
  logic [CNT_W-1:0] upc_iter_done;
  logic [CNT_W-1:0] upc_stall_cycles;

  // Side that owns the monitored function and reads back statistics
  modport master (
    output finish, mod_ap_start, mod_ap_ready, mod_ap_done, mod_ap_continue,
    output seq_cur_state, seq_pre_state, seq_post_state, seq_quit_state,
    output seq_iter_start_state, seq_iter_end_state,
    output upc_cur_state, upc_iter_start_state, upc_iter_end_state,
    output upc_iter_start_block, upc_iter_end_block,
    output upc_iter_start_enable, upc_iter_end_enable,
    output upc_loop_start, upc_loop_done, upc_loop_continue,
    input  mod_active, seq_active, upc_active, frozen,
    input  mod_txn_count, mod_busy_cycles, mod_last_latency,
    input  seq_loop_count, seq_iter_count,
    input  upc_loop_count, upc_iter_started, upc_iter_done, upc_stall_cycles
  );

  // Monitor side: only observes control signals, only drives statistics
  modport slave (
    input  finish, mod_ap_start, mod_ap_ready, mod_ap_done, mod_ap_continue,
    input  seq_cur_state, seq_pre_state, seq_post_state, seq_quit_state,
    input  seq_iter_start_state, seq_iter_end_state,
    input  upc_cur_state, upc_iter_start_state, upc_iter_end_state,
    input  upc_iter_start_block, upc_iter_end_block,
    input  upc_iter_start_enable, upc_iter_end_enable,
    input  upc_loop_start, upc_loop_done, upc_loop_continue,
    output mod_active, seq_active, upc_active, frozen,
    output mod_txn_count, mod_busy_cycles, mod_last_latency,
    output seq_loop_count, seq_iter_count,
    output upc_loop_count, upc_iter_started, upc_iter_done, upc_stall_cycles
  );
endinterface

// File: rtl/hls_activity_monitor.sv
// Passive activity monitor for one HLS function: tracks the block-level
// ap_* handshake, one sequential FSM loop and one pipelined loop, and keeps
// saturating counters that can be frozen by a sticky finish strobe.
module hls_activity_monitor #(
  parameter int SEQ_W = 6,
  parameter int UPC_W = 17,
  parameter int CNT_W = 32
) (
  input logic                  clock,
  input logic                  reset,
  hls_activity_monitor_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_BUSY} modState_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    satInc = (&v) ? v : v + CNT_W'(1);
  endfunction

  modState_t        r_mod_state, w_mod_state_next;
  logic [CNT_W-1:0] r_mod_lat, w_mod_lat_next;
  logic [CNT_W-1:0] r_mod_last, w_mod_last_next;
  logic [CNT_W-1:0] r_mod_txn, r_mod_busy;
  logic             w_mod_txn_done, w_mod_busy_inc, w_mod_dc;

  logic [SEQ_W-1:0] r_seq_prev;
  logic             r_seq_active;
  logic [CNT_W-1:0] r_seq_loop, r_seq_iter;
  logic             w_seq_entry, w_seq_exit, w_seq_comp;

  logic             r_upc_active;
  logic [CNT_W-1:0] r_upc_loop, r_upc_started, r_upc_done, r_upc_stall;
  logic             w_upc_set, w_upc_clr, w_upc_start_evt, w_upc_end_evt, w_upc_stall;

  logic             r_frozen;

  // ap_ready carries no information the counters need; it is tapped only so
  // the bundle mirrors the full handshake.
  logic             w_unused_ready;
  assign w_unused_ready = bus.mod_ap_ready;

  assign w_mod_dc = bus.mod_ap_done && bus.mod_ap_continue;

  // Block-level tracker next state: a start in IDLE either completes at once
  // (single-cycle call) or opens a transaction; a start during BUSY is ignored
  always_comb begin
    w_mod_state_next = r_mod_state;
    w_mod_lat_next   = r_mod_lat;
    w_mod_last_next  = r_mod_last;
    w_mod_txn_done   = 1'b0;
    w_mod_busy_inc   = 1'b0;
    case (r_mod_state)
      ST_IDLE: begin
        if (bus.mod_ap_start) begin
          w_mod_busy_inc = 1'b1;
          if (w_mod_dc) begin
            w_mod_txn_done  = 1'b1;
            w_mod_last_next = CNT_W'(1);
          end else begin
            w_mod_state_next = ST_BUSY;
            w_mod_lat_next   = CNT_W'(1);
          end
        end
      end
      ST_BUSY: begin
        w_mod_busy_inc = 1'b1;
        if (w_mod_dc) begin
          w_mod_txn_done   = 1'b1;
          w_mod_last_next  = satInc(r_mod_lat);
          w_mod_state_next = ST_IDLE;
        end else begin
          w_mod_lat_next = satInc(r_mod_lat);
        end
      end
      default: w_mod_state_next = ST_IDLE;
    endcase
  end

  // Block-level tracker registers, held while frozen
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mod_state <= ST_IDLE;
      r_mod_lat   <= '0;
      r_mod_last  <= '0;
      r_mod_txn   <= '0;
      r_mod_busy  <= '0;
    end else if (!r_frozen) begin
      r_mod_state <= w_mod_state_next;
      r_mod_lat   <= w_mod_lat_next;
      r_mod_last  <= w_mod_last_next;
      if (w_mod_txn_done) r_mod_txn  <= satInc(r_mod_txn);
      if (w_mod_busy_inc) r_mod_busy <= satInc(r_mod_busy);
    end
  end

  assign w_seq_entry = (r_seq_prev == bus.seq_pre_state) &&
                       (bus.seq_cur_state == bus.seq_iter_start_state);
  assign w_seq_exit  = (r_seq_prev == bus.seq_quit_state) &&
                       (bus.seq_cur_state == bus.seq_post_state);
  assign w_seq_comp  = r_seq_active && (r_seq_prev == bus.seq_iter_end_state) &&
                       (bus.seq_cur_state != bus.seq_iter_end_state);

  // Remember last cycle's sequential FSM state to detect transitions
  always_ff @(posedge clock) begin
    if (reset) r_seq_prev <= '0;
    else       r_seq_prev <= bus.seq_cur_state;
  end

  // Sequential loop entry/exit/iteration bookkeeping; entry beats exit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq_active <= 1'b0;
      r_seq_loop   <= '0;
      r_seq_iter   <= '0;
    end else if (!r_frozen) begin
      if (w_seq_comp) r_seq_iter <= satInc(r_seq_iter);
      if (w_seq_entry) begin
        r_seq_active <= 1'b1;
        r_seq_loop   <= satInc(r_seq_loop);
      end else if (w_seq_exit) begin
        r_seq_active <= 1'b0;
      end
    end
  end

  assign w_upc_set       = bus.upc_loop_start && !r_upc_active;
  assign w_upc_clr       = bus.upc_loop_done && bus.upc_loop_continue;
  assign w_upc_start_evt = (bus.upc_cur_state == bus.upc_iter_start_state) &&
                           bus.upc_iter_start_enable && !bus.upc_iter_start_block;
  assign w_upc_end_evt   = (bus.upc_cur_state == bus.upc_iter_end_state) &&
                           bus.upc_iter_end_enable && !bus.upc_iter_end_block;
  assign w_upc_stall     = r_upc_active && bus.upc_iter_start_block &&
                           (bus.upc_cur_state == bus.upc_iter_start_state);

  // Pipelined loop activity and per-stage iteration/stall counting
  always_ff @(posedge clock) begin
    if (reset) begin
      r_upc_active  <= 1'b0;
      r_upc_loop    <= '0;
      r_upc_started <= '0;
      r_upc_done    <= '0;
      r_upc_stall   <= '0;
    end else if (!r_frozen) begin
      if (w_upc_set) begin
        r_upc_active <= 1'b1;
        r_upc_loop   <= satInc(r_upc_loop);
      end else if (w_upc_clr) begin
        r_upc_active <= 1'b0;
      end
      if (w_upc_start_evt) r_upc_started <= satInc(r_upc_started);
      if (w_upc_end_evt)   r_upc_done    <= satInc(r_upc_done);
      if (w_upc_stall)     r_upc_stall   <= satInc(r_upc_stall);
    end
  end

  // Sticky freeze; the finish cycle itself still lets counters update
  always_ff @(posedge clock) begin
    if (reset) r_frozen <= 1'b0;
    else       r_frozen <= r_frozen | bus.finish;
  end

  assign bus.mod_active       = (r_mod_state == ST_BUSY);
  assign bus.seq_active       = r_seq_active;
  assign bus.upc_active       = r_upc_active;
  assign bus.frozen           = r_frozen;
  assign bus.mod_txn_count    = r_mod_txn;
  assign bus.mod_busy_cycles  = r_mod_busy;
  assign bus.mod_last_latency = r_mod_last;
  assign bus.seq_loop_count   = r_seq_loop;
  assign bus.seq_iter_count   = r_seq_iter;
  assign bus.upc_loop_count   = r_upc_loop;
  assign bus.upc_iter_started = r_upc_started;
  assign bus.upc_iter_done    = r_upc_done;
  assign bus.upc_stall_cycles = r_upc_stall;

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Bench for hls_activity_monitor: a full-width and a 4-bit-counter instance
// share one stimulus stream; a transaction-level model predicts every cycle.
module tb_hls_activity_monitor;
  localparam int SEQ_W   = 6;
  localparam int UPC_W   = 17;
  localparam int CNT_W   = 32;
  localparam int SMALL_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hls_activity_monitor_if #(.SEQ_W(SEQ_W), .UPC_W(UPC_W), .CNT_W(CNT_W))   bus();
  hls_activity_monitor_if #(.SEQ_W(SEQ_W), .UPC_W(UPC_W), .CNT_W(SMALL_W)) busSmall();

  hls_activity_monitor #(.SEQ_W(SEQ_W), .UPC_W(UPC_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  hls_activity_monitor #(.SEQ_W(SEQ_W), .UPC_W(UPC_W), .CNT_W(SMALL_W)) dutSmall (
    .clock(clock), .reset(reset), .bus(busSmall.slave));

  assign busSmall.finish                = bus.finish;
  assign busSmall.mod_ap_start          = bus.mod_ap_start;
  assign busSmall.mod_ap_ready          = bus.mod_ap_ready;
  assign busSmall.mod_ap_done           = bus.mod_ap_done;
  assign busSmall.mod_ap_continue       = bus.mod_ap_continue;
  assign busSmall.seq_cur_state         = bus.seq_cur_state;
  assign busSmall.seq_pre_state         = bus.seq_pre_state;
  assign busSmall.seq_post_state        = bus.seq_post_state;
  assign busSmall.seq_quit_state        = bus.seq_quit_state;
  assign busSmall.seq_iter_start_state  = bus.seq_iter_start_state;
  assign busSmall.seq_iter_end_state    = bus.seq_iter_end_state;
  assign busSmall.upc_cur_state         = bus.upc_cur_state;
  assign busSmall.upc_iter_start_state  = bus.upc_iter_start_state;
  assign busSmall.upc_iter_end_state    = bus.upc_iter_end_state;
  assign busSmall.upc_iter_start_block  = bus.upc_iter_start_block;
  assign busSmall.upc_iter_end_block    = bus.upc_iter_end_block;
  assign busSmall.upc_iter_start_enable = bus.upc_iter_start_enable;
  assign busSmall.upc_iter_end_enable   = bus.upc_iter_end_enable;
  assign busSmall.upc_loop_start        = bus.upc_loop_start;
  assign busSmall.upc_loop_done         = bus.upc_loop_done;
  assign busSmall.upc_loop_continue     = bus.upc_loop_continue;

  typedef struct packed {
    bit          modActive;
    bit          seqActive;
    bit          upcActive;
    bit          frozen;
    int unsigned txn;
    int unsigned busy;
    int unsigned lastLat;
    int unsigned seqLoop;
    int unsigned seqIter;
    int unsigned upcLoop;
    int unsigned upcStarted;
    int unsigned upcDone;
    int unsigned upcStall;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  // Model state: transactions tracked by start timestamp, counts unbounded
  expT         m;
  int unsigned mCyc;
  int unsigned mStartCyc;
  logic [SEQ_W-1:0] mSeqLast;

  // Predict what the outputs show after the coming edge, given current inputs
  task automatic modelStep();
    bit dc, entry, leave, comp, stallNow;
    if (reset) begin
      m = '0;
      mSeqLast = '0;
    end else begin
      if (!m.frozen) begin
        dc = bus.mod_ap_done && bus.mod_ap_continue;
        if (m.modActive) begin
          m.busy++;
          if (dc) begin
            m.txn++;
            m.lastLat = mCyc - mStartCyc + 1;
            m.modActive = 1'b0;
          end
        end else if (bus.mod_ap_start) begin
          m.busy++;
          if (dc) begin
            m.txn++;
            m.lastLat = 1;
          end else begin
            m.modActive = 1'b1;
            mStartCyc = mCyc;
          end
        end
        entry = (mSeqLast == bus.seq_pre_state) && (bus.seq_cur_state == bus.seq_iter_start_state);
        leave = (mSeqLast == bus.seq_quit_state) && (bus.seq_cur_state == bus.seq_post_state);
        comp  = m.seqActive && (mSeqLast == bus.seq_iter_end_state) &&
                (bus.seq_cur_state != bus.seq_iter_end_state);
        if (comp) m.seqIter++;
        if (entry) begin
          m.seqActive = 1'b1;
          m.seqLoop++;
        end else if (leave) begin
          m.seqActive = 1'b0;
        end
        stallNow = m.upcActive && bus.upc_iter_start_block &&
                   (bus.upc_cur_state == bus.upc_iter_start_state);
        if (stallNow) m.upcStall++;
        if (bus.upc_cur_state == bus.upc_iter_start_state && bus.upc_iter_start_enable &&
            !bus.upc_iter_start_block) m.upcStarted++;
        if (bus.upc_cur_state == bus.upc_iter_end_state && bus.upc_iter_end_enable &&
            !bus.upc_iter_end_block) m.upcDone++;
        if (bus.upc_loop_start && !m.upcActive) begin
          m.upcActive = 1'b1;
          m.upcLoop++;
        end else if (bus.upc_loop_done && bus.upc_loop_continue) begin
          m.upcActive = 1'b0;
        end
      end
      mSeqLast = bus.seq_cur_state;
      m.frozen = m.frozen | bus.finish;
    end
    mCyc++;
  endtask

  // One clock of stimulus: inputs already set by the caller
  task automatic applyStimulus();
    modelStep();
    sbQ.push_back(m);
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Scoreboard monitor: one expected snapshot per clock edge
  initial begin
    expT e;
    forever begin
      @(posedge clock);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("mod_active", bus.mod_active, e.modActive);
        checkOutput("seq_active", bus.seq_active, e.seqActive);
        checkOutput("upc_active", bus.upc_active, e.upcActive);
        checkOutput("frozen", bus.frozen, e.frozen);
        checkOutput("mod_txn_count", bus.mod_txn_count, e.txn);
        checkOutput("mod_busy_cycles", bus.mod_busy_cycles, e.busy);
        checkOutput("mod_last_latency", bus.mod_last_latency, e.lastLat);
        checkOutput("seq_loop_count", bus.seq_loop_count, e.seqLoop);
        checkOutput("seq_iter_count", bus.seq_iter_count, e.seqIter);
        checkOutput("upc_loop_count", bus.upc_loop_count, e.upcLoop);
        checkOutput("upc_iter_started", bus.upc_iter_started, e.upcStarted);
        checkOutput("upc_iter_done", bus.upc_iter_done, e.upcDone);
        checkOutput("upc_stall_cycles", bus.upc_stall_cycles, e.upcStall);
        checkOutput("small_frozen", busSmall.frozen, e.frozen);
        checkOutput("small_txn", busSmall.mod_txn_count, sat(e.txn, SMALL_W));
        checkOutput("small_busy", busSmall.mod_busy_cycles, sat(e.busy, SMALL_W));
        checkOutput("small_last_latency", busSmall.mod_last_latency, sat(e.lastLat, SMALL_W));
        checkOutput("small_seq_loop", busSmall.seq_loop_count, sat(e.seqLoop, SMALL_W));
        checkOutput("small_seq_iter", busSmall.seq_iter_count, sat(e.seqIter, SMALL_W));
        checkOutput("small_upc_started", busSmall.upc_iter_started, sat(e.upcStarted, SMALL_W));
        checkOutput("small_upc_done", busSmall.upc_iter_done, sat(e.upcDone, SMALL_W));
        checkOutput("small_upc_stall", busSmall.upc_stall_cycles, sat(e.upcStall, SMALL_W));
      end
    end
  end

  task automatic clearHandshakes();
    bus.finish = 0;
    bus.mod_ap_start = 0; bus.mod_ap_ready = 0; bus.mod_ap_done = 0; bus.mod_ap_continue = 0;
    bus.upc_iter_start_block = 0; bus.upc_iter_end_block = 0;
    bus.upc_iter_start_enable = 0; bus.upc_iter_end_enable = 0;
    bus.upc_loop_start = 0; bus.upc_loop_done = 0; bus.upc_loop_continue = 0;
    bus.upc_cur_state = 17'h2;
    bus.seq_cur_state = '0;
  endtask

  // Directed scenarios first, then a long randomized run
  initial begin
    logic [SEQ_W-1:0] seqTrace [10];
    logic [SEQ_W-1:0] seqPick [6];
    logic [UPC_W-1:0] upcPick [3];
    int drain;
    m = '0; mCyc = 0; mStartCyc = 0; mSeqLast = '0;
    reset = 1;
    bus.seq_pre_state = 6'd4; bus.seq_iter_start_state = 6'd5; bus.seq_quit_state = 6'd5;
    bus.seq_iter_end_state = 6'd6; bus.seq_post_state = 6'd1;
    bus.upc_iter_start_state = 17'h1; bus.upc_iter_end_state = 17'h4;
    clearHandshakes();
    repeat (3) applyStimulus();
    reset = 0;
    applyStimulus();

    $display("[TB] single transaction");
    bus.mod_ap_start = 1; applyStimulus();
    bus.mod_ap_start = 0; repeat (3) applyStimulus();
    bus.mod_ap_done = 1; bus.mod_ap_continue = 1; applyStimulus();
    clearHandshakes(); repeat (2) applyStimulus();

    $display("[TB] same-cycle start and done");
    repeat (3) begin
      bus.mod_ap_start = 1; bus.mod_ap_done = 1; bus.mod_ap_continue = 1; applyStimulus();
      clearHandshakes(); applyStimulus();
    end

    $display("[TB] sequential loop");
    seqTrace = '{6'd4, 6'd5, 6'd6, 6'd5, 6'd6, 6'd5, 6'd6, 6'd5, 6'd1, 6'd0};
    for (int i = 0; i < 10; i++) begin
      bus.seq_cur_state = seqTrace[i];
      applyStimulus();
    end

    $display("[TB] pipelined loop");
    bus.upc_loop_start = 1; applyStimulus();
    bus.upc_loop_start = 0;
    for (int i = 0; i < 12; i++) begin
      bus.upc_cur_state = 17'h1;
      bus.upc_iter_start_enable = 1;
      bus.upc_iter_start_block = (i == 3 || i == 4);
      applyStimulus();
    end
    bus.upc_iter_start_enable = 0; bus.upc_iter_start_block = 0;
    for (int i = 0; i < 10; i++) begin
      bus.upc_cur_state = 17'h4; bus.upc_iter_end_enable = 1; applyStimulus();
    end
    bus.upc_iter_end_enable = 0; bus.upc_cur_state = 17'h2;
    bus.upc_loop_done = 1; bus.upc_loop_continue = 1; applyStimulus();
    clearHandshakes(); applyStimulus();

    $display("[TB] saturation");
    repeat (20) begin
      bus.mod_ap_start = 1; bus.mod_ap_done = 1; bus.mod_ap_continue = 1; applyStimulus();
    end
    clearHandshakes(); applyStimulus();

    $display("[TB] freeze");
    bus.mod_ap_start = 1; applyStimulus();
    bus.mod_ap_start = 0; applyStimulus();
    bus.finish = 1; applyStimulus();
    bus.finish = 0; bus.mod_ap_done = 1; bus.mod_ap_continue = 1; repeat (2) applyStimulus();
    bus.mod_ap_start = 1; bus.upc_loop_start = 1; applyStimulus();
    clearHandshakes(); repeat (3) applyStimulus();
    reset = 1; applyStimulus();
    reset = 0; applyStimulus();

    $display("[TB] random run");
    seqPick = '{6'd4, 6'd5, 6'd6, 6'd1, 6'd0, 6'd5};
    upcPick = '{17'h1, 17'h4, 17'h2};
    for (int i = 0; i < 1500; i++) begin
      reset = (m.frozen && $urandom_range(0, 7) == 0) || ($urandom_range(0, 499) == 0);
      bus.finish = ($urandom_range(0, 299) == 0);
      bus.mod_ap_start = ($urandom_range(0, 2) == 0);
      bus.mod_ap_ready = $urandom_range(0, 1);
      bus.mod_ap_done = ($urandom_range(0, 2) == 0);
      bus.mod_ap_continue = ($urandom_range(0, 3) != 0);
      bus.seq_cur_state = seqPick[$urandom_range(0, 5)];
      bus.upc_cur_state = upcPick[$urandom_range(0, 2)];
      bus.upc_iter_start_block = ($urandom_range(0, 3) == 0);
      bus.upc_iter_end_block = ($urandom_range(0, 3) == 0);
      bus.upc_iter_start_enable = $urandom_range(0, 1);
      bus.upc_iter_end_enable = $urandom_range(0, 1);
      bus.upc_loop_start = ($urandom_range(0, 9) == 0);
      bus.upc_loop_done = ($urandom_range(0, 9) == 0) && !bus.upc_loop_start;
      bus.upc_loop_continue = $urandom_range(0, 1);
      applyStimulus();
    end
    reset = 0;
    clearHandshakes();
    applyStimulus();

    drain = 0;
    while (sbQ.size() != 0 && drain < 10) begin
      @(posedge clock);
      #2;
      drain++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
